// File: rtl/systolic_pkg.sv
// Shared defaults and FSM encoding for the systolic array feeder.
package systolic_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/feeder_tile_buf.sv
// N x N tile store: one row write port, N element read ports.
module feeder_tile_buf #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int RW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [RW-1:0]  wr_row,
  input  logic [N*W-1:0] wr_data,
  input  logic [N*RW-1:0] rd_row,
  input  logic [N*RW-1:0] rd_col,
  output logic [N*W-1:0] rd_data
);

  logic [W-1:0] mem [N][N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mem[r][c] <= '0;
    end else if (we) begin
      for (int c = 0; c < N; c++)
        mem[wr_row][c] <= wr_data[c*W +: W];
    end
  end

  // Write-through so a row loaded alongside start is seen by t=0.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < N; p++) begin
      logic [RW-1:0] r;
      logic [RW-1:0] c;
      r = rd_row[p*RW +: RW];
      c = rd_col[p*RW +: RW];
      if (we && (wr_row == r))
        rd_data[p*W +: W] = wr_data[c*W +: W];
      else
        rd_data[p*W +: W] = mem[r][c];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers A/B tiles and streams them skewed into an N x N array.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int W         = W_DEF,
  parameter int DRAIN_CYC = 2 * N,
  localparam int RW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic           load_sel,
  input  logic [RW-1:0]  load_row,
  input  logic [N*W-1:0] load_data,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] a_out,
  output logic [N*W-1:0] b_out,
  output logic           out_valid
);

  localparam int TW = $clog2(2 * N);
  localparam int DW = $clog2(DRAIN_CYC + 1);

  state_t        state, state_nxt;
  logic [TW-1:0] t, t_nxt;
  logic [DW-1:0] drn, drn_nxt;

  logic           wr_a, wr_b;
  logic [N*RW-1:0] lane_idx, lane_k;
  logic [N-1:0]   lane_ok;
  logic [N*W-1:0] a_rd, b_rd;
  logic [N*W-1:0] a_nxt, b_nxt;
  logic           stream_nxt;

  assign load_ready = (state == IDLE);
  assign busy       = (state == STREAM) || (state == DRAIN);
  assign done       = (state == DONE);
  assign wr_a       = load_valid && load_ready && !load_sel;
  assign wr_b       = load_valid && load_ready && load_sel;

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    drn_nxt   = drn;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          t_nxt     = '0;
        end
      end
      STREAM: begin
        if (t == TW'(2 * N - 2)) begin
          state_nxt = DRAIN;
          drn_nxt   = '0;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      DRAIN: begin
        if (drn == DW'(DRAIN_CYC - 1))
          state_nxt = DONE;
        else
          drn_nxt = drn + DW'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane p reads element t-p of its row (A) or column (B).
  always_comb begin
    lane_idx = '0;
    lane_k   = '0;
    lane_ok  = '0;
    for (int p = 0; p < N; p++) begin
      int d;
      d = int'(t_nxt) - p;
      lane_idx[p*RW +: RW] = RW'(p);
      lane_k[p*RW +: RW]   = RW'(d);
      lane_ok[p]           = (d >= 0) && (d < N);
    end
  end

  feeder_tile_buf #(.N(N), .W(W), .RW(RW)) u_buf_a (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_a),
    .wr_row  (load_row),
    .wr_data (load_data),
    .rd_row  (lane_idx),
    .rd_col  (lane_k),
    .rd_data (a_rd)
  );

  feeder_tile_buf #(.N(N), .W(W), .RW(RW)) u_buf_b (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_b),
    .wr_row  (load_row),
    .wr_data (load_data),
    .rd_row  (lane_k),
    .rd_col  (lane_idx),
    .rd_data (b_rd)
  );

  assign stream_nxt = (state_nxt == STREAM);

  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    for (int p = 0; p < N; p++) begin
      if (stream_nxt && lane_ok[p]) begin
        a_nxt[p*W +: W] = a_rd[p*W +: W];
        b_nxt[p*W +: W] = b_rd[p*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      t         <= '0;
      drn       <= '0;
      a_out     <= '0;
      b_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      t         <= t_nxt;
      drn       <= drn_nxt;
      a_out     <= a_nxt;
      b_out     <= b_nxt;
      out_valid <= stream_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench: tile model plus directed skew/timing vectors.
module tb_systolic_feeder;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int DC   = 8;
  localparam int LAST = 2 * N + DC;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_valid;
  logic           load_ready;
  logic           load_sel;
  logic [1:0]     load_row;
  logic [N*W-1:0] load_data;
  logic           start;
  logic           busy;
  logic           done;
  logic [N*W-1:0] a_out;
  logic [N*W-1:0] b_out;
  logic           out_valid;

  int checks = 0;
  int errors = 0;

  systolic_feeder #(.N(N), .W(W), .DRAIN_CYC(DC)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_sel   (load_sel),
    .load_row   (load_row),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .a_out      (a_out),
    .b_out      (b_out),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N*W-1:0] act,
                     input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: tiles plus k = cycles since start was sampled (-1 when idle).
  logic [W-1:0] ma [N][N];
  logic [W-1:0] mb [N][N];
  int  mk     = -1;
  bit  mdl_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mdl_on = 1'b1;
      mk     = -1;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          ma[r][c] = '0;
          mb[r][c] = '0;
        end
    end else if (mdl_on) begin
      if (mk < 0) begin
        if (load_valid)
          for (int c = 0; c < N; c++)
            if (load_sel) mb[load_row][c] = load_data[c*W +: W];
            else          ma[load_row][c] = load_data[c*W +: W];
        if (start) mk = 1;
      end else if (mk == LAST) begin
        mk = -1;
      end else begin
        mk++;
      end
    end
  end

  function automatic logic [N*W-1:0] exp_a(int k);
    logic [N*W-1:0] v = '0;
    if (k >= 1 && k <= 2 * N - 1)
      for (int i = 0; i < N; i++)
        if (k - 1 - i >= 0 && k - 1 - i < N)
          v[i*W +: W] = ma[i][k-1-i];
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_b(int k);
    logic [N*W-1:0] v = '0;
    if (k >= 1 && k <= 2 * N - 1)
      for (int j = 0; j < N; j++)
        if (k - 1 - j >= 0 && k - 1 - j < N)
          v[j*W +: W] = mb[k-1-j][j];
    return v;
  endfunction

  always @(negedge clk) begin
    if (mdl_on) begin
      logic [3:0] ec;
      ec = {mk < 0,
            mk >= 1 && mk <= 2 * N - 1 + DC,
            mk == LAST,
            mk >= 1 && mk <= 2 * N - 1};
      chk("a_out", a_out, exp_a(mk));
      chk("b_out", b_out, exp_b(mk));
      chk("ready_busy_done_valid",
          {124'd0, load_ready, busy, done, out_valid}, {124'd0, ec});
    end
  end

  logic [N*W-1:0] at [21];
  logic [N*W-1:0] bt [21];
  logic [N*W-1:0] sa [21];
  logic [N*W-1:0] sb [21];
  int ov, dn, dat;

  task automatic run(input bit ld7, input bit poke, input int rst_at);
    ov = 0; dn = 0; dat = -1;
    for (int n = 0; n < 21; n++) begin
      at[n] = '0;
      bt[n] = '0;
    end
    start = 1'b1;
    if (ld7) begin
      load_valid = 1'b1;
      load_sel   = 1'b0;
      load_row   = 2'd2;
      load_data  = {4{32'd7}};
    end
    @(posedge clk); #1;
    start = 1'b0;
    load_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      at[n] = a_out;
      bt[n] = b_out;
      if (out_valid) ov++;
      if (done) begin dn++; dat = n; end
      if (poke && n == 3) begin
        start = 1'b1; load_valid = 1'b1; load_sel = 1'b1;
        load_row = 2'd0; load_data = '1;
      end
      if (poke && n == 4) begin
        chk("poke_ready", {127'd0, load_ready}, '0);
        start = 1'b0; load_valid = 1'b0;
      end
      if (rst_at == n) rst = 1'b1;
      if (rst_at != 0 && n == rst_at + 1) begin
        chk("rst_outs", a_out | b_out, '0);
        chk("rst_ctl", {124'd0, load_ready, busy, done, out_valid},
            {124'd0, 4'b1000});
        rst = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [N*W-1:0] acc;
    bit same;
    rst = 1'b1; load_valid = 1'b0; load_sel = 1'b0;
    load_row = '0; load_data = '0; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {124'd0, load_ready, busy, done, out_valid},
        {124'd0, 4'b1000});
    chk("reset_a", a_out, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < N; i++)
      for (int s = 0; s < 2; s++) begin
        load_valid = 1'b1;
        load_sel   = s[0];
        load_row   = 2'(i);
        for (int k = 0; k < N; k++)
          load_data[k*W +: W] = s ? 32'(100 + 16*i + k) : 32'(16*i + k);
        @(posedge clk); #1;
      end
    load_valid = 1'b0;

    run(0, 0, 0);
    chk("t0_a", at[1], '0);
    chk("t3_a", at[4], {32'd48, 32'd33, 32'd18, 32'd3});
    chk("t3_b", bt[4], {32'd103, 32'd118, 32'd133, 32'd148});
    chk("t6_a", at[7], {32'd51, 96'd0});
    chk("valid_cycles", 128'(ov), 128'd7);
    chk("done_at", 128'(dat), 128'd16);
    chk("done_count", 128'(dn), 128'd1);
    for (int n = 0; n < 21; n++) begin sa[n] = at[n]; sb[n] = bt[n]; end

    run(0, 0, 0);
    same = 1'b1;
    for (int n = 0; n < 21; n++)
      if (at[n] !== sa[n] || bt[n] !== sb[n]) same = 1'b0;
    chk("replay_same", {127'd0, same}, 128'd1);
    chk("replay_done_count", 128'(dn), 128'd1);

    run(0, 1, 0);
    chk("poke_done_at", 128'(dat), 128'd16);
    chk("poke_done_count", 128'(dn), 128'd1);
    run(0, 0, 0);
    same = 1'b1;
    for (int n = 0; n < 21; n++)
      if (at[n] !== sa[n] || bt[n] !== sb[n]) same = 1'b0;
    chk("poke_bufs_kept", {127'd0, same}, 128'd1);

    run(1, 0, 0);
    for (int n = 3; n <= 6; n++)
      chk("ld7_lane2", {96'd0, at[n][2*W +: W]}, 128'd7);

    run(0, 0, 4);
    run(0, 0, 0);
    acc = '0;
    for (int n = 0; n < 21; n++) acc = acc | at[n] | bt[n];
    chk("post_rst_zero", acc, '0);
    chk("post_rst_valid", 128'(ov), 128'd7);
    chk("post_rst_done_at", 128'(dat), 128'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
